// File: rtl/fixed3_inv_issuer_pkg.sv
// fixed3_inv_issuer_pkg: Fixed-point types and issuer state/result types.
package fixed3_inv_issuer_pkg;

    typedef logic signed [31:0] Fixed;

    typedef struct packed {
        Fixed x;
        Fixed y;
        Fixed z;
    } Fixed3;

    localparam int INV_TAG_W = 8;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, CAPT} InvIssState;

    typedef struct packed {
        Fixed3                  ov;
        logic [INV_TAG_W-1:0]   tag;
        logic                   err;
    } InvResult;

    function automatic Fixed _Fixed(input int i);
        return Fixed'(i <<< 16);
    endfunction

endpackage

// File: rtl/inv_result_fifo.sv
// inv_result_fifo: DEPTH-entry FIFO with occupancy counter and registered head (no fall-through).
module inv_result_fifo #(
    parameter int DEPTH = 2,
    parameter type T = logic
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  T     wdata,
    input  logic pop,
    output T     rdata,
    output logic empty,
    output logic full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    T               mem [DEPTH];
    logic [AW-1:0]  wr;
    logic [AW-1:0]  rd;
    logic [CW-1:0]  cnt;
    logic           do_push;
    logic           do_pop;

    assign empty   = cnt == '0;
    assign full    = cnt == CW'(DEPTH);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd];

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr  <= '0;
            rd  <= '0;
            cnt <= '0;
        end else begin
            if (do_push) wr <= wr + 1'b1;
            if (do_pop) rd <= rd + 1'b1;
            cnt <= cnt + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr] <= wdata;
    end

endmodule

// File: rtl/fixed3_inv_issuer.sv
// fixed3_inv_issuer: Wraps a strobe/valid Fixed3 reciprocal unit into valid/ready streams with tags.
module fixed3_inv_issuer
    import fixed3_inv_issuer_pkg::*;
#(
    parameter int TAG_W     = 8,
    parameter int BLANK_CYC = 2,
    parameter int TIMEOUT   = 64,
    parameter int OQ_DEPTH  = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  Fixed3            in_v,
    input  logic [TAG_W-1:0] in_tag,
    output logic             inv_strobe,
    output Fixed3            inv_v,
    input  logic             inv_valid,
    input  Fixed3            inv_ov,
    output logic             out_valid,
    input  logic             out_ready,
    output Fixed3            out_ov,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err,
    output logic             busy
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef struct packed {
        Fixed3            ov;
        logic [TAG_W-1:0] tag;
        logic             err;
    } res_t;

    InvIssState       state;
    InvIssState       nxt;
    logic [CW-1:0]    cnt;
    logic [TAG_W-1:0] tag_q;
    Fixed3            ov_q;
    logic             err_q;
    logic             hit;
    logic             expire;
    logic             empty;
    logic             full;
    res_t             head;
    res_t             wdata;

    // Reserving a free slot before issue guarantees CAPT never sees a full queue.
    assign in_ready   = state == IDLE && !full && !reset;
    assign inv_strobe = state == ISSUE && !reset;
    assign hit        = inv_valid && cnt >= CW'(BLANK_CYC);
    assign expire     = cnt == CW'(TIMEOUT - 1);
    assign busy       = state != IDLE || !empty;
    assign out_valid  = !empty;
    assign out_ov     = head.ov;
    assign out_tag    = head.tag;
    assign out_err    = head.err;
    assign wdata      = '{ov: ov_q, tag: tag_q, err: err_q};

    always_comb begin
        nxt = state;
        nxt = state == IDLE  ? (in_valid && in_ready ? ISSUE : IDLE) :
              state == ISSUE ? WAIT :
              state == WAIT  ? (hit || expire ? CAPT : WAIT) : IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            tag_q <= '0;
            inv_v <= '0;
            ov_q  <= '0;
            err_q <= 1'b0;
        end else begin
            state <= nxt;
            if (state == IDLE && in_valid && in_ready) begin
                inv_v <= in_v;
                tag_q <= in_tag;
            end
            cnt <= state == ISSUE ? '0 : state == WAIT ? cnt + 1'b1 : cnt;
            // Result is sampled while inv_valid is known good; timeout forces zero lanes.
            if (state == WAIT && (hit || expire)) begin
                ov_q  <= hit ? inv_ov : '0;
                err_q <= !hit;
            end
        end
    end

    inv_result_fifo #(.DEPTH(OQ_DEPTH), .T(res_t)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (state == CAPT),
        .wdata (wdata),
        .pop   (out_ready),
        .rdata (head),
        .empty (empty),
        .full  (full)
    );

endmodule

// File: tb/tb_fixed3_inv_issuer.sv
// tb_fixed3_inv_issuer: directed tests of the issuer against a behavioural reciprocal unit.
module tb_fixed3_inv_issuer;
    import fixed3_inv_issuer_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    Fixed3      in_v = '0;
    logic [7:0] in_tag = '0;
    logic       inv_strobe;
    Fixed3      inv_v;
    logic       inv_valid = 1'b0;
    Fixed3      inv_ov = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    Fixed3      out_ov;
    logic [7:0] out_tag;
    logic       out_err;
    logic       busy;

    int checks = 0;
    int passed = 0;
    int cyc = 0;

    // Reciprocal unit model knobs
    int delay = 1;
    bit never = 1'b0;
    bit stale = 1'b0;
    int cd = 0;
    bit drop = 1'b0;
    int strobes = 0;
    int strobe_cyc = 0;

    fixed3_inv_issuer #(.TAG_W(8), .BLANK_CYC(2), .TIMEOUT(64), .OQ_DEPTH(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_v       (in_v),
        .in_tag     (in_tag),
        .inv_strobe (inv_strobe),
        .inv_v      (inv_v),
        .inv_valid  (inv_valid),
        .inv_ov     (inv_ov),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_ov     (out_ov),
        .out_tag    (out_tag),
        .out_err    (out_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic Fixed recip(input Fixed x);
        longint q;
        if (x == 0) return '0;
        q = 64'sh1_0000_0000 / longint'(x);
        return Fixed'(q);
    endfunction

    // Level-style result valid: stays high until the next strobe (optionally one cycle past it).
    always @(negedge clk) begin
        if (drop) begin
            drop = 1'b0;
            inv_valid = 1'b0;
        end
        if (cd > 0) begin
            cd--;
            if (cd == 0) begin
                inv_valid = 1'b1;
                inv_ov = '{x: recip(inv_v.x), y: recip(inv_v.y), z: recip(inv_v.z)};
            end
        end
        if (inv_strobe) begin
            strobes++;
            strobe_cyc = cyc;
            if (stale) drop = 1'b1;
            else inv_valid = 1'b0;
            cd = never ? 0 : delay;
        end
    end

    task automatic send(input logic [95:0] v, input logic [7:0] t);
        in_v = Fixed3'(v);
        in_tag = t;
        in_valid = 1'b1;
        for (int i = 0; i < 300 && !in_ready; i++) @(negedge clk);
        checks++;
        if (!in_ready) $display("FAIL send_accept tag=%h in_ready=%b required 1", t, in_ready);
        else passed++;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic recv(output logic [95:0] ov, output logic [7:0] tag, output logic err, output int lat);
        for (int i = 0; i < 300 && !out_valid; i++) @(negedge clk);
        checks++;
        if (!out_valid) $display("FAIL recv_wait out_valid=%b required 1", out_valid);
        else passed++;
        ov = out_ov;
        tag = out_tag;
        err = out_err;
        lat = cyc - strobe_cyc;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) $display("FAIL reset_in_ready got=%b required 0", in_ready);
        else passed++;
        checks++;
        if (inv_strobe !== 1'b0) $display("FAIL reset_strobe got=%b required 0", inv_strobe);
        else passed++;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b required 0", out_valid);
        else passed++;
        checks++;
        if (busy !== 1'b0) $display("FAIL reset_busy got=%b required 0", busy);
        else passed++;
        checks++;
        if (inv_v !== '0) $display("FAIL reset_inv_v got=%h required 0", inv_v);
        else passed++;
        checks++;
        if (in_ready !== 1'b1) $display("FAIL reset_idle_ready got=%b required 1", in_ready);
        else passed++;
    endtask

    task automatic test_basic();
        logic [95:0] ov;
        logic [7:0] tag;
        logic err;
        int lat;
        strobes = 0;
        send({32'h0002_0000, 32'h0004_0000, 32'hFFFF_8000}, 8'h11);
        recv(ov, tag, err, lat);
        checks++;
        if (ov !== {32'h0000_8000, 32'h0000_4000, 32'hFFFE_0000}) $display("FAIL basic_ov got=%h required 00008000_00004000_fffe0000", ov);
        else passed++;
        checks++;
        if (tag !== 8'h11) $display("FAIL basic_tag got=%h required 11", tag);
        else passed++;
        checks++;
        if (err !== 1'b0) $display("FAIL basic_err got=%b required 0", err);
        else passed++;
        checks++;
        if (lat !== 5) $display("FAIL basic_latency got=%0d required 5", lat);
        else passed++;
        checks++;
        if (strobes !== 1) $display("FAIL basic_strobes got=%0d required 1", strobes);
        else passed++;
    endtask

    task automatic test_zero_lane();
        logic [95:0] ov;
        logic [7:0] tag;
        logic err;
        int lat;
        send({32'h0, 32'h0001_0000, 32'h0008_0000}, 8'h22);
        recv(ov, tag, err, lat);
        checks++;
        if (ov !== {32'h0, 32'h0001_0000, 32'h0000_2000}) $display("FAIL zero_ov got=%h required 0_00010000_00002000", ov);
        else passed++;
        checks++;
        if (tag !== 8'h22 || err !== 1'b0) $display("FAIL zero_tag_err got=%h/%b required 22/0", tag, err);
        else passed++;
    endtask

    task automatic test_stale_valid();
        logic [95:0] ov;
        logic [7:0] tag;
        logic err;
        int lat;
        stale = 1'b1;
        delay = 11;
        send({32'h0004_0000, 32'hFFFE_0000, 32'h0000_4000}, 8'h33);
        recv(ov, tag, err, lat);
        checks++;
        if (ov !== {32'h0000_4000, 32'hFFFF_8000, 32'h0004_0000}) $display("FAIL stale_ov got=%h required 00004000_ffff8000_00040000", ov);
        else passed++;
        checks++;
        if (lat !== 13) $display("FAIL stale_latency got=%0d required 13", lat);
        else passed++;
        stale = 1'b0;
        delay = 1;
    endtask

    task automatic test_back_pressure();
        logic [7:0] tags [3];
        int n = 0;
        bit acc = 1'b0;
        strobes = 0;
        send({32'h0002_0000, 32'h0002_0000, 32'h0002_0000}, 8'h41);
        send({32'h0001_0000, 32'h0001_0000, 32'h0001_0000}, 8'h42);
        in_v = Fixed3'({32'h0008_0000, 32'h0008_0000, 32'h0008_0000});
        in_tag = 8'h43;
        in_valid = 1'b1;
        repeat (20) @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) $display("FAIL bp_in_ready got=%b required 0", in_ready);
        else passed++;
        checks++;
        if (out_valid !== 1'b1 || busy !== 1'b1) $display("FAIL bp_out_valid_busy got=%b/%b required 1/1", out_valid, busy);
        else passed++;
        checks++;
        if (strobes !== 2) $display("FAIL bp_strobes got=%0d required 2", strobes);
        else passed++;
        out_ready = 1'b1;
        for (int i = 0; i < 100 && n < 3; i++) begin
            if (acc) in_valid = 1'b0;
            if (in_valid && in_ready) acc = 1'b1;
            if (out_valid) begin
                tags[n] = out_tag;
                n++;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (n !== 3) $display("FAIL bp_drain_count got=%0d required 3", n);
        else passed++;
        checks++;
        if (tags[0] !== 8'h41 || tags[1] !== 8'h42 || tags[2] !== 8'h43)
            $display("FAIL bp_order got=%h,%h,%h required 41,42,43", tags[0], tags[1], tags[2]);
        else passed++;
    endtask

    task automatic test_timeout();
        logic [95:0] ov;
        logic [7:0] tag;
        logic err;
        int lat;
        never = 1'b1;
        send({32'h0001_0000, 32'h0002_0000, 32'h0004_0000}, 8'h55);
        recv(ov, tag, err, lat);
        checks++;
        if (err !== 1'b1 || ov !== '0) $display("FAIL timeout_err_ov got=%b/%h required 1/0", err, ov);
        else passed++;
        checks++;
        if (tag !== 8'h55) $display("FAIL timeout_tag got=%h required 55", tag);
        else passed++;
        checks++;
        if (lat !== 66) $display("FAIL timeout_latency got=%0d required 66", lat);
        else passed++;
        never = 1'b0;
        send({32'h0002_0000, 32'h0004_0000, 32'hFFFF_8000}, 8'h56);
        recv(ov, tag, err, lat);
        checks++;
        if (err !== 1'b0 || ov !== {32'h0000_8000, 32'h0000_4000, 32'hFFFE_0000})
            $display("FAIL timeout_next got=%b/%h required 0/00008000_00004000_fffe0000", err, ov);
        else passed++;
    endtask

    task automatic test_reset_mid_op();
        delay = 20;
        send({32'h0002_0000, 32'h0002_0000, 32'h0002_0000}, 8'h66);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || inv_strobe !== 1'b0) $display("FAIL rst_mid_during got=%b/%b required 0/0", in_ready, inv_strobe);
        else passed++;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL rst_mid_after got=%b/%b/%b required 0/0/1", out_valid, busy, in_ready);
        else passed++;
        repeat (30) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) $display("FAIL rst_mid_late got=%b/%b required 0/0", out_valid, busy);
        else passed++;
        delay = 1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_lane();
        test_stale_valid();
        test_back_pressure();
        test_timeout();
        test_reset_mid_op();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
